idex_operand_stage: RTL and testbench

//   ID/EX pipeline register plus operand forwarding and load-use hazard detection.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/idex_operand_stage_fwd_mux.sv | 36 +++
 rtl/idex_operand_stage.sv | 117 +++++++++++
 tb/tb_idex_operand_stage.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared widths and the ID/EX slot record for the operand stage.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic              use_pc;
        logic              use_imm;
        logic              sub;
        logic              reg_write;
        logic              mem_read;
    } idex_slot_t;

endpackage

// File: rtl/idex_operand_stage_fwd_mux.sv
// Per-operand forwarding select: EX/MEM over MEM/WB over slot value, x0 pinned to zero.
// Forwarding paths exist only when FORWARDING_EN is defined.
module operand_fwd_mux
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   slot_data,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   data
);

`ifndef FORWARDING_EN
    logic unused_fwd;
    assign unused_fwd = ^{exmem_rd, exmem_reg_write, exmem_result,
                          memwb_rd, memwb_reg_write, memwb_result};
`endif

    // Later assignments win, so the x0 override sits last.
    always_comb begin
        data = slot_data;
`ifdef FORWARDING_EN
        if (memwb_reg_write && memwb_rd == rs)
            data = memwb_result;
        if (exmem_reg_write && exmem_rd == rs)
            data = exmem_result;
`endif
        if (rs == '0)
            data = '0;
    end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX register with operand forwarding and load-use / RAW hazard back-pressure.
// FORWARDING_EN selects forwarding (load-use stall only); otherwise RAW stalls on EX and EX/MEM.
module idex_operand_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_use_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              id_use_pc,
    input  logic              id_sub,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic              alu_sub,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [XLEN-1:0]   ex_store_data
);

    idex_slot_t      slot;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            hazard;
    logic            dep_ex;

    assign dep_ex = (id_use_rs1 && slot.rd == id_rs1) || (id_use_rs2 && slot.rd == id_rs2);

`ifdef FORWARDING_EN
    assign hazard = id_valid && ex_valid && slot.mem_read && (slot.rd != '0) && dep_ex;
`else
    // MEM/WB is covered by the write-through register file, so only EX and EX/MEM block.
    logic dep_exmem;
    assign dep_exmem = (id_use_rs1 && exmem_rd == id_rs1) || (id_use_rs2 && exmem_rd == id_rs2);
    assign hazard = id_valid &&
                    ((ex_valid && slot.reg_write && (slot.rd != '0) && dep_ex) ||
                     (exmem_reg_write && (exmem_rd != '0) && dep_exmem));
`endif

    assign id_ready = !ex_stall && !hazard && !flush;

    operand_fwd_mux u_fwd_rs1 (
        .rs              (slot.rs1),
        .slot_data       (slot.rs1_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .data            (fwd_rs1)
    );

    operand_fwd_mux u_fwd_rs2 (
        .rs              (slot.rs2),
        .slot_data       (slot.rs2_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .data            (fwd_rs2)
    );

    // A held slot refreshes its operands so producers retiring during a stall are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= '0;
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_stall) begin
            slot.rs1_data <= fwd_rs1;
            slot.rs2_data <= fwd_rs2;
        end else if (hazard) begin
            ex_valid <= 1'b0;
        end else begin
            slot <= '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                      rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                      imm: id_imm, pc: id_pc,
                      use_pc: id_use_pc, use_imm: id_use_imm, sub: id_sub,
                      reg_write: id_reg_write, mem_read: id_mem_read};
            ex_valid <= id_valid;
        end
    end

    assign alu_a         = slot.use_pc  ? slot.pc  : fwd_rs1;
    assign alu_b         = slot.use_imm ? slot.imm : fwd_rs2;
    assign alu_sub       = slot.sub;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = slot.rd;
    assign ex_reg_write  = ex_valid && slot.reg_write;
    assign ex_mem_read   = ex_valid && slot.mem_read;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Bench for idex_operand_stage: directed vector table, hand sequences and a randomized model run.
module tb_idex_operand_stage;
    import riscv_pkg::*;

    typedef struct {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic              use_imm;
        logic              use_pc;
        logic              sub;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              flush;
        logic              stall;
        logic [REG_AW-1:0] xm_rd;
        logic              xm_we;
        logic [XLEN-1:0]   xm_res;
        logic [REG_AW-1:0] mw_rd;
        logic              mw_we;
        logic [XLEN-1:0]   mw_res;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic          exp_ready;
        logic          exp_valid;
        logic [31:0]   exp_a;
        logic [31:0]   exp_b;
        logic [31:0]   exp_res;
    } vec_t;

`ifdef FORWARDING_EN
    localparam logic [31:0] EXP_V4        = 32'd100;
    localparam logic [31:0] EXP_V5        = 32'd7;
    localparam int          EXP_LU_STALLS = 1;
    localparam logic [31:0] EXP_HELD_B    = 32'hFFFF_FFF1;
`else
    localparam logic [31:0] EXP_V4        = 32'd55;
    localparam logic [31:0] EXP_V5        = 32'd55;
    localparam int          EXP_LU_STALLS = 2;
    localparam logic [31:0] EXP_HELD_B    = 32'h0000_0022;
`endif

    logic              clk;
    logic              rst;
    stim_t             cur;
    logic              id_ready;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic              alu_sub;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [XLEN-1:0]   ex_store_data;

    int n_cmp = 0;
    int n_err = 0;

    bit              m_valid;
    stim_t           m_s;
    logic [XLEN-1:0] m_r1;
    logic [XLEN-1:0] m_r2;

    idex_operand_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (cur.valid),
        .id_ready        (id_ready),
        .id_rs1          (cur.rs1),
        .id_rs2          (cur.rs2),
        .id_use_rs1      (cur.use_rs1),
        .id_use_rs2      (cur.use_rs2),
        .id_rs1_data     (cur.rs1_data),
        .id_rs2_data     (cur.rs2_data),
        .id_imm          (cur.imm),
        .id_use_imm      (cur.use_imm),
        .id_pc           (cur.pc),
        .id_use_pc       (cur.use_pc),
        .id_sub          (cur.sub),
        .id_rd           (cur.rd),
        .id_reg_write    (cur.reg_write),
        .id_mem_read     (cur.mem_read),
        .flush           (cur.flush),
        .ex_stall        (cur.stall),
        .exmem_rd        (cur.xm_rd),
        .exmem_reg_write (cur.xm_we),
        .exmem_result    (cur.xm_res),
        .memwb_rd        (cur.mw_rd),
        .memwb_reg_write (cur.mw_we),
        .memwb_result    (cur.mw_res),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_sub         (alu_sub),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_store_data   (ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [31:0] add_sub32();
        return alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    endfunction

    // Reference: value a source register would read in EX, given this cycle's producers.
    function automatic logic [XLEN-1:0] m_fwd(input logic [REG_AW-1:0] rs, input logic [XLEN-1:0] v);
        if (rs == 0) return '0;
`ifdef FORWARDING_EN
        if (cur.xm_we && cur.xm_rd == rs) return cur.xm_res;
        if (cur.mw_we && cur.mw_rd == rs) return cur.mw_res;
`endif
        return v;
    endfunction

    // Reference: registers not yet readable by ID, as a bitmask over the register file.
    function automatic bit m_hazard();
        logic [31:0] blocked;
        blocked = '0;
`ifdef FORWARDING_EN
        if (m_valid && m_s.mem_read) blocked[m_s.rd] = 1'b1;
`else
        if (m_valid && m_s.reg_write) blocked[m_s.rd] = 1'b1;
        if (cur.xm_we) blocked[cur.xm_rd] = 1'b1;
`endif
        blocked[0] = 1'b0;
        return cur.valid && ((cur.use_rs1 && blocked[cur.rs1]) || (cur.use_rs2 && blocked[cur.rs2]));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_s     = idle();
        m_r1    = '0;
        m_r2    = '0;
    endtask

    task automatic model_advance();
        logic [XLEN-1:0] n1, n2;
        if (cur.flush) begin
            m_valid = 1'b0;
        end else if (cur.stall) begin
            n1 = m_fwd(m_s.rs1, m_r1);
            n2 = m_fwd(m_s.rs2, m_r2);
            m_r1 = n1;
            m_r2 = n2;
        end else if (m_hazard()) begin
            m_valid = 1'b0;
        end else begin
            m_s     = cur;
            m_r1    = cur.rs1_data;
            m_r2    = cur.rs2_data;
            m_valid = cur.valid;
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        cur = s;
        @(negedge clk);
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        cur = idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic checkOutput();
        logic [XLEN-1:0] f1, f2;
        f1 = m_fwd(m_s.rs1, m_r1);
        f2 = m_fwd(m_s.rs2, m_r2);
        checkVal("rnd_ready", 32'(id_ready), 32'(!cur.stall && !m_hazard() && !cur.flush));
        checkVal("rnd_valid", 32'(ex_valid), 32'(m_valid));
        checkVal("rnd_alu_a", alu_a, m_s.use_pc ? m_s.pc : f1);
        checkVal("rnd_alu_b", alu_b, m_s.use_imm ? m_s.imm : f2);
        checkVal("rnd_store", ex_store_data, f2);
        checkVal("rnd_sub", 32'(alu_sub), 32'(m_s.sub));
        checkVal("rnd_rd", 32'(ex_rd), 32'(m_s.rd));
        checkVal("rnd_regwr", 32'(ex_reg_write), 32'(m_valid && m_s.reg_write));
        checkVal("rnd_memrd", 32'(ex_mem_read), 32'(m_valid && m_s.mem_read));
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle();
        s.valid     = ($urandom_range(0, 9) < 7);
        s.rs1       = REG_AW'($urandom_range(0, 3));
        s.rs2       = REG_AW'($urandom_range(0, 3));
        s.use_rs1   = 1'($urandom_range(0, 1));
        s.use_rs2   = 1'($urandom_range(0, 1));
        s.rs1_data  = $urandom;
        s.rs2_data  = $urandom;
        s.imm       = $urandom;
        s.pc        = $urandom;
        s.use_imm   = ($urandom_range(0, 3) == 0);
        s.use_pc    = ($urandom_range(0, 3) == 0);
        s.sub       = 1'($urandom_range(0, 1));
        s.rd        = REG_AW'($urandom_range(0, 3));
        s.reg_write = 1'($urandom_range(0, 1));
        s.mem_read  = ($urandom_range(0, 2) == 0);
        s.flush     = ($urandom_range(0, 9) == 0);
        s.stall     = ($urandom_range(0, 4) == 0);
        s.xm_rd     = REG_AW'($urandom_range(0, 3));
        s.xm_we     = 1'($urandom_range(0, 1));
        s.xm_res    = $urandom;
        s.mw_rd     = REG_AW'($urandom_range(0, 3));
        s.mw_we     = 1'($urandom_range(0, 1));
        s.mw_res    = $urandom;
        return s;
    endfunction

    initial begin
        vec_t  vecs[$];
        vec_t  v;
        stim_t s, lw, add, ins, other;
        int    age, stalls;
        bit    accepted;

        rst = 1'b1;
        cur = idle();
        model_reset();

        // Directed table: inputs this cycle and the outputs expected in the same cycle.
        v = '{s: idle(), exp_ready: 1, exp_valid: 0, exp_a: 0, exp_b: 0, exp_res: 0};
        vecs.push_back(v);
        v.s = idle(); v.s.valid = 1; v.s.rs1 = 1; v.s.rs2 = 2; v.s.use_rs1 = 1; v.s.use_rs2 = 1;
        v.s.rs1_data = 10; v.s.rs2_data = 5; v.s.rd = 3; v.s.reg_write = 1;
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 1, exp_valid: 1, exp_a: 10, exp_b: 5, exp_res: 15};
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 1, exp_valid: 0, exp_a: 0, exp_b: 0, exp_res: 0};
        v.s.valid = 1; v.s.rs1 = 1; v.s.use_rs1 = 1; v.s.rs1_data = 55;
        v.s.use_imm = 1; v.s.imm = 4; v.s.rd = 4; v.s.reg_write = 1;
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 0, exp_valid: 1, exp_a: EXP_V4, exp_b: 4, exp_res: EXP_V4 + 4};
        v.s.stall = 1; v.s.xm_rd = 1; v.s.xm_we = 1; v.s.xm_res = 100;
        v.s.mw_rd = 1; v.s.mw_we = 1; v.s.mw_res = 7;
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 0, exp_valid: 1, exp_a: EXP_V5, exp_b: 4, exp_res: EXP_V5 + 4};
        v.s.stall = 1; v.s.mw_rd = 1; v.s.mw_we = 1; v.s.mw_res = 7;
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 0, exp_valid: 1, exp_a: EXP_V5, exp_b: 4, exp_res: EXP_V5 + 4};
        v.s.stall = 1;
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 1, exp_valid: 1, exp_a: EXP_V5, exp_b: 4, exp_res: EXP_V5 + 4};
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 1, exp_valid: 0, exp_a: 0, exp_b: 0, exp_res: 0};
        v.s.valid = 1; v.s.use_rs1 = 1; v.s.use_rs2 = 1; v.s.rd = 6; v.s.reg_write = 1;
        v.s.xm_rd = 0; v.s.xm_we = 1; v.s.xm_res = 32'hDEAD;
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 1, exp_valid: 1, exp_a: 0, exp_b: 0, exp_res: 0};
        v.s.xm_we = 1; v.s.xm_res = 32'hDEAD; v.s.mw_we = 1; v.s.mw_res = 32'hBEEF;
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 1, exp_valid: 0, exp_a: 0, exp_b: 0, exp_res: 0};
        v.s.valid = 1; v.s.rs1 = 3; v.s.rs2 = 4; v.s.use_rs1 = 1; v.s.use_rs2 = 1;
        v.s.rs1_data = 20; v.s.rs2_data = 30; v.s.sub = 1; v.s.rd = 8; v.s.reg_write = 1;
        vecs.push_back(v);
        v = '{s: idle(), exp_ready: 1, exp_valid: 1, exp_a: 20, exp_b: 30, exp_res: 32'hFFFF_FFF6};
        vecs.push_back(v);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s);
            checkVal($sformatf("vec%0d_ready", i), 32'(id_ready), 32'(vecs[i].exp_ready));
            checkVal($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].exp_valid));
            checkVal($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].exp_a);
            checkVal($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].exp_b);
            checkVal($sformatf("vec%0d_result", i), add_sub32(), vecs[i].exp_res);
            tick();
        end

        // Load-use: hold the dependent add in ID until accepted, aging the load downstream.
        doReset();
        lw = idle(); lw.valid = 1; lw.rs1 = 1; lw.rs1_data = 32'h100; lw.use_rs1 = 1;
        lw.use_imm = 1; lw.imm = 8; lw.rd = 5; lw.reg_write = 1; lw.mem_read = 1;
        add = idle(); add.valid = 1; add.rs1 = 5; add.rs2 = 2; add.use_rs1 = 1; add.use_rs2 = 1;
        add.rs2_data = 3; add.rd = 6; add.reg_write = 1;
        applyStimulus(lw);
        checkVal("lu_lw_ready", 32'(id_ready), 1);
        tick();
        age = 1; stalls = 0; accepted = 0;
        for (int c = 0; c < 8 && !accepted; c++) begin
            s = add;
            if (age == 2) begin s.xm_rd = 5; s.xm_we = 1; s.xm_res = 32'h108; end
            if (age == 3) begin s.mw_rd = 5; s.mw_we = 1; s.mw_res = 32'h55; end
            if (age >= 3) s.rs1_data = 32'h55;
            applyStimulus(s);
            if (age == 1) checkVal("lu_ex_is_load", 32'(ex_mem_read), 1);
            if (age == 2) checkVal("lu_bubble", 32'(ex_valid), 0);
            if (id_ready) accepted = 1; else stalls++;
            tick();
            age++;
        end
        checkVal("lu_accepted", 32'(accepted), 1);
        checkVal("lu_stall_cycles", 32'(stalls), 32'(EXP_LU_STALLS));
        s = idle();
        if (age == 3) begin s.mw_rd = 5; s.mw_we = 1; s.mw_res = 32'h55; end
        applyStimulus(s);
        checkVal("lu_add_valid", 32'(ex_valid), 1);
        checkVal("lu_add_a", alu_a, 32'h55);
        checkVal("lu_add_b", alu_b, 32'h3);
        checkVal("lu_add_result", add_sub32(), 32'h58);
        tick();

        // Stall retention: MEM/WB retires x2 during a 3-cycle hold; ID traffic must not leak in.
        doReset();
        ins = idle(); ins.valid = 1; ins.rs1 = 1; ins.rs2 = 2; ins.use_rs1 = 1; ins.use_rs2 = 1;
        ins.rs1_data = 10; ins.rs2_data = 32'h22; ins.rd = 7; ins.reg_write = 1;
        other = idle(); other.valid = 1; other.rs1 = 9; other.rs2 = 9; other.use_rs1 = 1;
        other.use_rs2 = 1; other.rs1_data = 32'h99; other.rs2_data = 32'h99; other.rd = 9;
        applyStimulus(ins);
        tick();
        for (int i = 0; i < 3; i++) begin
            s = other; s.stall = 1;
            if (i == 0) begin s.mw_rd = 2; s.mw_we = 1; s.mw_res = 32'hFFFF_FFF1; end
            applyStimulus(s);
            checkVal($sformatf("st_ready%0d", i), 32'(id_ready), 0);
            checkVal($sformatf("st_valid%0d", i), 32'(ex_valid), 1);
            tick();
        end
        applyStimulus(idle());
        checkVal("st_rel_ready", 32'(id_ready), 1);
        checkVal("st_rel_alu_a", alu_a, 10);
        checkVal("st_rel_alu_b", alu_b, EXP_HELD_B);
        checkVal("st_rel_store", ex_store_data, EXP_HELD_B);
        checkVal("st_rel_rd", 32'(ex_rd), 7);
        tick();

        // Flush wins over a coincident stall.
        applyStimulus(ins);
        tick();
        s = other; s.stall = 1; s.flush = 1;
        applyStimulus(s);
        checkVal("fl_pre_valid", 32'(ex_valid), 1);
        checkVal("fl_ready", 32'(id_ready), 0);
        tick();
        applyStimulus(idle());
        checkVal("fl_valid", 32'(ex_valid), 0);
        tick();

        // Reset in the middle of a stall clears every output.
        s = ins; s.sub = 1; s.mem_read = 1; s.use_pc = 1; s.pc = 32'h400;
        applyStimulus(s);
        tick();
        s = idle(); s.stall = 1;
        applyStimulus(s);
        checkVal("rs_pre_valid", 32'(ex_valid), 1);
        checkVal("rs_pre_alu_a", alu_a, 32'h400);
        tick();
        rst = 1'b1;
        applyStimulus(s);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("rs_alu_a", alu_a, 0);
        checkVal("rs_alu_b", alu_b, 0);
        checkVal("rs_store", ex_store_data, 0);
        checkVal("rs_sub", 32'(alu_sub), 0);
        checkVal("rs_valid", 32'(ex_valid), 0);
        checkVal("rs_rd", 32'(ex_rd), 0);
        checkVal("rs_regwr", 32'(ex_reg_write), 0);
        checkVal("rs_memrd", 32'(ex_mem_read), 0);
        rst = 1'b0;

        // Randomized run against the reference model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(rand_stim());
            checkOutput();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
